// File: rtl/snap_pkg.sv
// Shared definitions for the snapshot capture controller: FSM states and
// bit positions inside the 32-bit control word.
package snap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TRIG = 2'd1,
    CAPTURE   = 2'd2,
    DONE      = 2'd3
  } snap_state_e;

  localparam int ARM      = 0;
  localparam int TRIG_SEL = 1;
  localparam int WE_SEL   = 2;
  localparam int ABORT    = 3;

endpackage

// File: rtl/snap_edge_det.sv
// Rising-edge detector for the arm bit. The first cycle after reset never
// reports an edge, so an arm level held through reset is not mistaken for a new arm.
module snap_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev;
  logic primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= 1'b0;
      primed <= 1'b0;
    end else begin
      prev   <= level;
      primed <= 1'b1;
    end
  end

  assign rise = level & ~prev & primed;

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arms from a control register, optionally waits for
// an external trigger, then streams 2^ADDR_W qualified samples into a BRAM.
//
// state     | meaning
// IDLE      | waiting for an arm edge (also entered on abort)
// WAIT_TRIG | armed, waiting for trig_ext
// CAPTURE   | writing qualified samples
// DONE      | buffer full, waiting for a re-arm
module snap_capture_ctrl
  import snap_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [31:0]       ctrl,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              trig_ext,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_data,
  output logic              bram_we,
  output logic [31:0]       status
);

  localparam int unsigned     LAST_I = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W:0] LAST   = LAST_I[ADDR_W:0];

  snap_state_e       state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [ADDR_W:0]   count, count_nx;
  logic              arm_rise;
  logic              qual;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              unused_ctrl;

  assign unused_ctrl = ^ctrl[31:4];

  snap_edge_det u_arm_edge (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .level (ctrl[ARM]),
    .rise  (arm_rise)
  );

  assign qual = ctrl[WE_SEL] | din_valid;

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    count_nx = count;
    wr_en    = 1'b0;
    if (ctrl[ABORT]) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (arm_rise) begin
            addr_nx  = '0;
            count_nx = '0;
            state_nx = ctrl[TRIG_SEL] ? WAIT_TRIG : CAPTURE;
          end
        end
        WAIT_TRIG: begin
          if (trig_ext) begin
            state_nx = CAPTURE;
            wr_en    = qual;
          end
        end
        CAPTURE: wr_en = qual;
        default: state_nx = IDLE;
      endcase
      // Address wraps naturally; leaving CAPTURE on the last write stops it being reused.
      if (wr_en) begin
        addr_nx  = addr + 1'b1;
        count_nx = count + 1'b1;
        if (count == LAST) state_nx = DONE;
      end
    end
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      count     <= '0;
      bram_we   <= 1'b0;
      bram_addr <= '0;
      bram_data <= '0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      count   <= count_nx;
      bram_we <= wr_en;
      if (wr_en) begin
        bram_addr <= addr;
        bram_data <= din;
      end
    end
  end

  assign busy   = (state == WAIT_TRIG) || (state == CAPTURE);
  assign done   = (state == DONE);
  assign status = {done, busy, {(29 - ADDR_W){1'b0}}, count};

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl with a per-cycle behavioural model of the
// capture rules plus hand-computed expectations for each scenario.
module tb_snap_capture_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              user_clk = 1'b0;
  logic              user_rst_n = 1'b0;
  logic [31:0]       ctrl = '0;
  logic [DATA_W-1:0] din = '0;
  logic              din_valid = 1'b0;
  logic              trig_ext = 1'b0;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;
  logic              bram_we;
  logic [31:0]       status;

  snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .user_clk   (user_clk),
    .user_rst_n (user_rst_n),
    .ctrl       (ctrl),
    .din        (din),
    .din_valid  (din_valid),
    .trig_ext   (trig_ext),
    .bram_addr  (bram_addr),
    .bram_data  (bram_data),
    .bram_we    (bram_we),
    .status     (status)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // model: arm history, activity flags and number of words written
  logic m_prev = 1'b1;
  logic m_wait = 1'b0;
  logic m_cap = 1'b0;
  logic m_done = 1'b0;
  int   m_n = 0;
  logic exp_we = 1'b0;
  logic [ADDR_W-1:0] exp_addr = '0;
  logic [DATA_W-1:0] exp_data = '0;

  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];
  int                log_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[31] = m_done;
    s[30] = m_wait | m_cap;
    s[ADDR_W:0] = m_n[ADDR_W:0];
    return s;
  endfunction

  task automatic model_step();
    logic edge_seen;
    edge_seen = ctrl[0] & ~m_prev;
    m_prev = ctrl[0];
    exp_we = 1'b0;
    if (ctrl[3]) begin
      m_wait = 1'b0;
      m_cap  = 1'b0;
      m_done = 1'b0;
    end else if (!m_wait && !m_cap) begin
      if (edge_seen) begin
        m_n = 0;
        m_done = 1'b0;
        if (ctrl[1]) m_wait = 1'b1;
        else         m_cap = 1'b1;
      end
    end else if (m_cap || trig_ext) begin
      m_wait = 1'b0;
      m_cap  = 1'b1;
      if (ctrl[2] || din_valid) begin
        exp_we   = 1'b1;
        exp_addr = ADDR_W'(m_n % DEPTH);
        exp_data = din;
        m_n++;
        if (m_n == DEPTH) begin
          m_cap  = 1'b0;
          m_done = 1'b1;
        end
      end
    end
  endtask

  always @(posedge user_clk) begin
    cyc++;
    if (!user_rst_n) begin
      m_prev = 1'b1;
      m_wait = 1'b0;
      m_cap  = 1'b0;
      m_done = 1'b0;
      m_n    = 0;
      exp_we = 1'b0;
    end else begin
      model_step();
    end
    #1;
    chk("we", {31'b0, bram_we}, {31'b0, exp_we});
    chk("status", status, model_status());
    if (exp_we) begin
      chk("addr", {28'b0, bram_addr}, {28'b0, exp_addr});
      chk("data", {16'b0, bram_data}, {16'b0, exp_data});
    end
    if (bram_we) begin
      log_addr.push_back(bram_addr);
      log_data.push_back(bram_data);
      log_cyc.push_back(cyc);
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge user_clk);
      ctrl = 32'h0;
      trig_ext = 1'b0;
      din_valid = 1'b0;
    end
  endtask

  task automatic drive_cycles(input logic [31:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge user_clk);
      ctrl = c;
    end
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge user_clk);
    chk("rst_status", status, 32'h0);
    chk("rst_we", {31'b0, bram_we}, 32'h0);
    user_rst_n = 1'b1;
    idle_cycles(3);

    // immediate capture
    clear_log();
    for (int c = 0; c < 22; c++) begin
      @(negedge user_clk);
      ctrl = 32'h5;
      din = DATA_W'(16'h0FF + c);
    end
    chk("imm_count", log_addr.size(), 16);
    if (log_addr.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk("imm_addr", {28'b0, log_addr[i]}, i);
        chk("imm_data", {16'b0, log_data[i]}, 32'h100 + i);
      end
      chk("imm_consecutive", log_cyc[15] - log_cyc[0], 15);
    end
    chk("imm_status", status, 32'h8000_0010);
    idle_cycles(2);

    // external trigger
    clear_log();
    for (int c = 0; c < 60; c++) begin
      @(negedge user_clk);
      if (c == 10) chk("ext_busy", status, 32'h4000_0000);
      ctrl = 32'h3;
      trig_ext = (c == 20);
      din = DATA_W'(16'h200 + c);
      din_valid = (c % 2 == 0);
    end
    chk("ext_count", log_addr.size(), 16);
    if (log_addr.size() > 0) chk("ext_first", {16'b0, log_data[0]}, 32'h214);
    chk("ext_status", status, 32'h8000_0010);
    idle_cycles(2);

    // abort after five writes
    clear_log();
    for (int c = 0; c < 6; c++) begin
      @(negedge user_clk);
      ctrl = 32'h5;
      din = DATA_W'(16'h300 + c);
    end
    @(negedge user_clk);
    ctrl = 32'h8;
    idle_cycles(3);
    chk("abort_count", log_addr.size(), 5);
    chk("abort_status", status, 32'h0000_0005);
    clear_log();
    drive_cycles(32'h5, 20);
    chk("rearm_count", log_addr.size(), 16);
    if (log_addr.size() > 0) chk("rearm_addr0", {28'b0, log_addr[0]}, 0);
    idle_cycles(2);

    // arm toggle during capture is ignored
    clear_log();
    for (int c = 0; c < 30; c++) begin
      @(negedge user_clk);
      ctrl = (c == 8) ? 32'h4 : 32'h5;
      din = DATA_W'(16'h400 + c);
    end
    chk("toggle_count", log_addr.size(), 16);
    if (log_addr.size() == 16) chk("toggle_last_addr", {28'b0, log_addr[15]}, 15);
    chk("toggle_status", status, 32'h8000_0010);
    idle_cycles(2);

    // reset mid-capture with arm held high
    clear_log();
    for (int c = 0; c < 6; c++) begin
      @(negedge user_clk);
      ctrl = 32'h5;
      din = DATA_W'(16'h500 + c);
    end
    @(negedge user_clk);
    user_rst_n = 1'b0;
    #1;
    chk("midrst_we", {31'b0, bram_we}, 32'h0);
    chk("midrst_addr", {28'b0, bram_addr}, 32'h0);
    chk("midrst_data", {16'b0, bram_data}, 32'h0);
    chk("midrst_status", status, 32'h0);
    repeat (2) @(negedge user_clk);
    user_rst_n = 1'b1;
    clear_log();
    drive_cycles(32'h5, 10);
    chk("post_rst_writes", log_addr.size(), 0);
    chk("post_rst_status", status, 32'h0);
    drive_cycles(32'h4, 1);
    drive_cycles(32'h5, 20);
    chk("post_rst_rearm", log_addr.size(), 16);
    idle_cycles(2);

    // abort together with an arm edge
    clear_log();
    drive_cycles(32'h9, 1);
    idle_cycles(4);
    chk("abort_arm_busy_done", {30'b0, status[31:30]}, 32'h0);
    chk("abort_arm_writes", log_addr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
